// File: rtl/estimator_sched_if.sv
// Bus bundle between the estimator scheduler, the PE phase/coupling memories
// and the in-PE estimator. clk/reset stay outside as plain ports.
//
// Handshake: start is a level sampled only while the scheduler is idle. It has
// no ready. busy is high from the cycle after acceptance until done. done is a
// single-cycle pulse during which grad_sum/ham_sum are final. Both memories
// return data on the cycle after their rd_en strobe, unconditionally.
interface estimator_sched_if #(
   parameter int IDX_W    = 6,
   parameter int PHASE_W  = 8,
   parameter int FACTOR_W = 8,
   parameter int NL_W     = 16,
   parameter int ACC_W    = 32
);
   logic                start;
   logic [IDX_W-1:0]    spin_idx;
   logic                busy;
   logic                done;
   logic                ph_rd_en;
   logic [IDX_W-1:0]    ph_rd_addr;
   logic [PHASE_W-1:0]  ph_rd_data;
   logic                cpl_rd_en;
   logic [IDX_W-1:0]    cpl_rd_addr;
   logic [FACTOR_W-1:0] cpl_rd_data;
   logic                est_ena;
   logic [PHASE_W-1:0]  est_self_phase;
   logic [PHASE_W-1:0]  est_cpl_phase;
   logic [FACTOR_W-1:0] est_factor;
   logic [NL_W-1:0]     est_gradient;
   logic [NL_W-1:0]     est_hamilt;
   logic [ACC_W-1:0]    grad_sum;
   logic [ACC_W-1:0]    ham_sum;

   // Scheduler side
   modport master (
      input  start, spin_idx, ph_rd_data, cpl_rd_data, est_gradient, est_hamilt,
      output busy, done, ph_rd_en, ph_rd_addr, cpl_rd_en, cpl_rd_addr,
             est_ena, est_self_phase, est_cpl_phase, est_factor, grad_sum, ham_sum
   );

   // Memories, estimator and PE update logic side
   modport slave (
      output start, spin_idx, ph_rd_data, cpl_rd_data, est_gradient, est_hamilt,
      input  busy, done, ph_rd_en, ph_rd_addr, cpl_rd_en, cpl_rd_addr,
             est_ena, est_self_phase, est_cpl_phase, est_factor, grad_sum, ham_sum
   );
endinterface

// File: rtl/estimator_sched.sv
// Estimator scheduler: walks one spin through a full neighbour sweep.
// Fetches the self phase, issues every neighbour j (phase and coupling in the
// same cycle), presents the factor one cycle after its neighbour phase, and
// accumulates the returned gradient/Hamiltonian terms into wrapping sums.
// Timeline for acceptance in cycle S: SELF S+1, SWEEP S+2..S+1+N,
// DRAIN S+N+2..S+N+4, DONE S+N+5.
module estimator_sched #(
   parameter int NUM_SPIN = 64,
   parameter int IDX_W    = 6,
   parameter int PHASE_W  = 8,
   parameter int FACTOR_W = 8,
   parameter int NL_W     = 16,
   parameter int ACC_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   estimator_sched_if.master bus,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SELF  = 3'd1,
      S_SWEEP = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [IDX_W-1:0] LAST_J = IDX_W'(NUM_SPIN - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    spin_q, spin_d;
   logic [1:0]          drain_q, drain_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                ph_rd_en_q, ph_rd_en_d;
   logic [IDX_W-1:0]    ph_rd_addr_q, ph_rd_addr_d;
   logic                cpl_rd_en_q, cpl_rd_en_d;
   logic [IDX_W-1:0]    cpl_rd_addr_q, cpl_rd_addr_d;
   logic                est_ena_q, est_ena_d;

   // Pipeline tracking: mem_* = read data on the bus this cycle,
   // ph_v = est_cpl_phase holds a neighbour, fac_v = est_factor holds a term.
   logic                mem_self_q, mem_self_d;
   logic                mem_v_q, mem_v_d;
   logic                mem_excl_q, mem_excl_d;
   logic                ph_v_q, ph_v_d;
   logic                fac_v_q, fac_v_d;
   logic [FACTOR_W-1:0] fac_stage_q, fac_stage_d;
   logic [PHASE_W-1:0]  est_self_phase_q, est_self_phase_d;
   logic [PHASE_W-1:0]  est_cpl_phase_q, est_cpl_phase_d;
   logic [FACTOR_W-1:0] est_factor_q, est_factor_d;
   logic [ACC_W-1:0]    grad_sum_q, grad_sum_d;
   logic [ACC_W-1:0]    ham_sum_q, ham_sum_d;

   // Next-state: sequencing FSM, read issue, data alignment and accumulation
   always_comb begin
      state_d          = state_q;
      spin_d           = spin_q;
      drain_d          = drain_q;
      busy_d           = busy_q;
      done_d           = 1'b0;
      ph_rd_en_d       = 1'b0;
      ph_rd_addr_d     = ph_rd_addr_q;
      cpl_rd_en_d      = 1'b0;
      cpl_rd_addr_d    = cpl_rd_addr_q;
      est_ena_d        = 1'b0;
      grad_sum_d       = grad_sum_q;
      ham_sum_d        = ham_sum_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d      = S_SELF;
               spin_d       = bus.spin_idx;
               busy_d       = 1'b1;
               ph_rd_en_d   = 1'b1;
               ph_rd_addr_d = bus.spin_idx;
               grad_sum_d   = '0;
               ham_sum_d    = '0;
            end
         end
         S_SELF: begin
            state_d       = S_SWEEP;
            ph_rd_en_d    = 1'b1;
            ph_rd_addr_d  = '0;
            cpl_rd_en_d   = 1'b1;
            cpl_rd_addr_d = '0;
            est_ena_d     = 1'b1;
         end
         S_SWEEP: begin
            est_ena_d = 1'b1;
            if (ph_rd_addr_q == LAST_J) begin
               state_d = S_DRAIN;
               drain_d = 2'd0;
            end else begin
               ph_rd_en_d    = 1'b1;
               ph_rd_addr_d  = ph_rd_addr_q + 1'b1;
               cpl_rd_en_d   = 1'b1;
               cpl_rd_addr_d = cpl_rd_addr_q + 1'b1;
            end
         end
         S_DRAIN: begin
            // Three cycles: the last term is summed at the end of the third
            if (drain_q == 2'd2) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               drain_d   = drain_q + 2'd1;
               est_ena_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // Tag what the memories return next cycle
      mem_self_d = (state_q == S_SELF);
      mem_v_d    = (state_q == S_SWEEP);
      mem_excl_d = (state_q == S_SWEEP) && (ph_rd_addr_q == spin_q);

      // Self phase and neighbour phase captured straight from read data
      est_self_phase_d = mem_self_q ? bus.ph_rd_data : est_self_phase_q;
      est_cpl_phase_d  = mem_v_q ? bus.ph_rd_data : est_cpl_phase_q;

      // Factor held one extra stage so it trails its phase by a cycle;
      // the self-coupling term is forced to zero
      fac_stage_d  = (mem_v_q && !mem_excl_q) ? bus.cpl_rd_data : '0;
      ph_v_d       = mem_v_q;
      est_factor_d = ph_v_q ? fac_stage_q : '0;
      fac_v_d      = ph_v_q;

      // Estimator terms are valid in the cycle est_factor carries a term
      if (fac_v_q) begin
         grad_sum_d = grad_sum_q + ACC_W'(signed'(bus.est_gradient));
         ham_sum_d  = ham_sum_q + ACC_W'(signed'(bus.est_hamilt));
      end
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= S_IDLE;
         spin_q           <= '0;
         drain_q          <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         ph_rd_en_q       <= 1'b0;
         ph_rd_addr_q     <= '0;
         cpl_rd_en_q      <= 1'b0;
         cpl_rd_addr_q    <= '0;
         est_ena_q        <= 1'b0;
         mem_self_q       <= 1'b0;
         mem_v_q          <= 1'b0;
         mem_excl_q       <= 1'b0;
         ph_v_q           <= 1'b0;
         fac_v_q          <= 1'b0;
         fac_stage_q      <= '0;
         est_self_phase_q <= '0;
         est_cpl_phase_q  <= '0;
         est_factor_q     <= '0;
         grad_sum_q       <= '0;
         ham_sum_q        <= '0;
      end else begin
         state_q          <= state_d;
         spin_q           <= spin_d;
         drain_q          <= drain_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         ph_rd_en_q       <= ph_rd_en_d;
         ph_rd_addr_q     <= ph_rd_addr_d;
         cpl_rd_en_q      <= cpl_rd_en_d;
         cpl_rd_addr_q    <= cpl_rd_addr_d;
         est_ena_q        <= est_ena_d;
         mem_self_q       <= mem_self_d;
         mem_v_q          <= mem_v_d;
         mem_excl_q       <= mem_excl_d;
         ph_v_q           <= ph_v_d;
         fac_v_q          <= fac_v_d;
         fac_stage_q      <= fac_stage_d;
         est_self_phase_q <= est_self_phase_d;
         est_cpl_phase_q  <= est_cpl_phase_d;
         est_factor_q     <= est_factor_d;
         grad_sum_q       <= grad_sum_d;
         ham_sum_q        <= ham_sum_d;
      end
   end

   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.ph_rd_en       = ph_rd_en_q;
   assign bus.ph_rd_addr     = ph_rd_addr_q;
   assign bus.cpl_rd_en      = cpl_rd_en_q;
   assign bus.cpl_rd_addr    = cpl_rd_addr_q;
   assign bus.est_ena        = est_ena_q;
   assign bus.est_self_phase = est_self_phase_q;
   assign bus.est_cpl_phase  = est_cpl_phase_q;
   assign bus.est_factor     = est_factor_q;
   assign bus.grad_sum       = grad_sum_q;
   assign bus.ham_sum        = ham_sum_q;
   assign dbg_state          = state_q;

endmodule
